// File: rtl/riscv_memory_responder_pkg.sv
// Shared constants and request classification for the core's memory responder.
package riscv_core_p;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1001_0000;
    localparam int unsigned WORD_BYTES        = 4;
    localparam int unsigned WORD_SHIFT        = 2;

    typedef enum logic [1:0] {
        DREQ_IDLE,
        DREQ_READ,
        DREQ_WRITE,
        DREQ_ILLEGAL
    } dreq_e;

    function automatic dreq_e classify_dreq(
        input logic rd,
        input logic wr,
        input logic aligned,
        input logic in_range
    );
        if (!rd && !wr) return DREQ_IDLE;
        if (rd && wr) return DREQ_ILLEGAL;
        if (!aligned || !in_range) return DREQ_ILLEGAL;
        return rd ? DREQ_READ : DREQ_WRITE;
    endfunction

endpackage

// File: rtl/riscv_sync_ram.sv
// Single-clock RAM: one registered read port, one write port, read-first.
module riscv_sync_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
        if (we) mem[waddr] <= wdata;
    end

endmodule

// File: rtl/riscv_memory_responder.sv
// Instruction/data memory responder: one-cycle fetch and load, legality checks,
// fault pulses and saturating transaction counters.
module riscv_memory_responder
    import riscv_core_p::*;
#(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  TEXT_BASE  = XLEN'(TEXT_BASE_DEFAULT),
    parameter logic [XLEN-1:0]  DATA_BASE  = XLEN'(DATA_BASE_DEFAULT),
    parameter int unsigned      TEXT_WORDS = 1024,
    parameter int unsigned      DATA_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PC,
    output logic [31:0]     instruction,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [XLEN-1:0] dAddress,
    input  logic [XLEN-1:0] dWriteData,
    output logic [XLEN-1:0] dReadData,
    output logic            iFault,
    output logic            dFault,
    output logic [15:0]     rdCount,
    output logic [15:0]     wrCount
);

    localparam int unsigned TAW = $clog2(TEXT_WORDS);
    localparam int unsigned DAW = $clog2(DATA_WORDS);
    localparam logic [XLEN-1:0] TEXT_BYTES = XLEN'(WORD_BYTES * TEXT_WORDS);
    localparam logic [XLEN-1:0] DATA_BYTES = XLEN'(WORD_BYTES * DATA_WORDS);

    logic [XLEN-1:0] t_off, d_off;
    logic            fetch_ok;
    dreq_e           dreq;
    logic            d_we;
    logic [31:0]     t_rdata;
    logic [XLEN-1:0] d_rdata;

    logic            i_ok_q, i_fault_q;
    logic            rd_pend_q, d_fault_q;
    logic [XLEN-1:0] d_hold_q;
    logic [15:0]     rd_cnt_q, wr_cnt_q;

    // Offsets below the base wrap to huge values, so one unsigned compare covers both bounds.
    always_comb begin
        t_off    = PC - TEXT_BASE;
        d_off    = dAddress - DATA_BASE;
        fetch_ok = (PC[WORD_SHIFT-1:0] == '0) && (t_off < TEXT_BYTES);
        dreq     = classify_dreq(MemRead, MemWrite,
                                 dAddress[WORD_SHIFT-1:0] == '0, d_off < DATA_BYTES);
        d_we     = (dreq == DREQ_WRITE) && !rst;
    end

    riscv_sync_ram #(.WIDTH(32), .DEPTH(TEXT_WORDS)) u_text (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (t_off[TAW+WORD_SHIFT-1:WORD_SHIFT]),
        .rdata (t_rdata)
    );

    riscv_sync_ram #(.WIDTH(XLEN), .DEPTH(DATA_WORDS)) u_data (
        .clk   (clk),
        .we    (d_we),
        .waddr (d_off[DAW+WORD_SHIFT-1:WORD_SHIFT]),
        .wdata (dWriteData),
        .raddr (d_off[DAW+WORD_SHIFT-1:WORD_SHIFT]),
        .rdata (d_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            i_ok_q    <= 1'b0;
            i_fault_q <= 1'b0;
            rd_pend_q <= 1'b0;
            d_fault_q <= 1'b0;
            d_hold_q  <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            i_ok_q    <= fetch_ok;
            i_fault_q <= !fetch_ok;
            rd_pend_q <= (dreq == DREQ_READ);
            d_fault_q <= (dreq == DREQ_ILLEGAL);
            // Latch whatever dReadData currently shows so idle cycles keep it.
            if (dreq == DREQ_ILLEGAL) d_hold_q <= '0;
            else if (rd_pend_q)       d_hold_q <= d_rdata;
            if (dreq == DREQ_READ && rd_cnt_q != '1)  rd_cnt_q <= rd_cnt_q + 16'd1;
            if (dreq == DREQ_WRITE && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign instruction = i_ok_q ? t_rdata : '0;
    assign iFault      = i_fault_q;
    assign dReadData   = rd_pend_q ? d_rdata : d_hold_q;
    assign dFault      = d_fault_q;
    assign rdCount     = rd_cnt_q;
    assign wrCount     = wr_cnt_q;

endmodule

// File: doc/riscv_memory_responder.md
RISCV_MEMORY_RESPONDER -- requirements
Module: riscv_memory_responder

Interface
REQ-001 Parameter TEXT_BASE, default 32'h00400000, byte address of instruction memory word 0.
REQ-002 Parameter DATA_BASE, default 32'h10010000, byte address of data memory word 0.
REQ-003 Parameter TEXT_WORDS, default 1024, instruction memory depth in 32-bit words (power of two).
REQ-004 Parameter DATA_WORDS, default 1024, data memory depth in 32-bit words (power of two).
REQ-005 Parameter XLEN, default 32, data and address width.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 PC  input  XLEN  fetch byte address from the core.
REQ-009 instruction  output  32  fetched word for PC of previous cycle.
REQ-010 MemRead  input  1  data read request.
REQ-011 MemWrite  input  1  data write request.
REQ-012 dAddress  input  XLEN  data byte address.
REQ-013 dWriteData  input  XLEN  store data.
REQ-014 dReadData  output  XLEN  load data for request of previous cycle.
REQ-015 iFault  output  1  fetch of previous cycle was misaligned or out of range.
REQ-016 dFault  output  1  data request of previous cycle was illegal.
REQ-017 rdCount, wrCount  output  16 each  completed legal data reads and writes.

Function
REQ-018 Fetch latency SHALL be exactly one cycle: instruction after edge N equals text word (PC-TEXT_BASE)>>2 sampled at edge N.
REQ-019 Fetch SHALL be legal only if PC[1:0]==0 and TEXT_BASE <= PC < TEXT_BASE+4*TEXT_WORDS; otherwise instruction=0 and iFault=1 for that one cycle.
REQ-020 Data request SHALL be legal only if exactly one of MemRead/MemWrite is high, dAddress[1:0]==0, and DATA_BASE <= dAddress < DATA_BASE+4*DATA_WORDS.
REQ-021 Legal write SHALL update word (dAddress-DATA_BASE)>>2 at the sampling edge; dReadData unchanged.
REQ-022 Legal read SHALL present the word on dReadData one cycle later; a write at edge N followed by read of same word at edge N+1 SHALL return the new data.
REQ-023 Illegal request (including MemRead and MemWrite both high) SHALL perform no write, drive dReadData=0 and dFault=1 for one cycle.
REQ-024 Neither MemRead nor MemWrite high: dReadData SHALL hold its previous value, dFault=0.
REQ-025 Address compare SHALL use unsigned XLEN-bit arithmetic; base+size overflow past 2^XLEN is a configuration error, not handled.
REQ-026 rdCount/wrCount SHALL increment by one per legal read/write and saturate at 16'hFFFF.
REQ-027 Fault flags SHALL be one-cycle pulses, never sticky.

Reset
REQ-028 While rst high: instruction=0, dReadData=0, iFault=0, dFault=0, rdCount=0, wrCount=0; no memory write occurs even if MemWrite high.
REQ-029 Memory contents SHALL NOT be cleared by reset; a write in the cycle rst asserts is discarded.
REQ-030 First fetch after rst deasserts SHALL return text word 0 when PC=TEXT_BASE.

Structure
REQ-031 TEXT_BASE/DATA_BASE defaults and word-alignment constants SHALL live in riscv_core_p.
REQ-032 One sub-module riscv_sync_ram (one synchronous read port, one write port, read-first) SHALL be instantiated for text and for data.
REQ-033 Legality decode and counters SHALL be in the top module.

Verification
REQ-034 Reset then PC=32'h00400000, text word0=32'h00500093 -> instruction=32'h00500093 next cycle, iFault=0.
REQ-035 Write 32'hDEADBEEF to 32'h10010008, next cycle read 32'h10010008 -> dReadData=32'hDEADBEEF, wrCount=1, rdCount=1.
REQ-036 Read 32'h10010002 -> dReadData=0, dFault=1 one cycle, rdCount unchanged.
REQ-037 MemRead=MemWrite=1 at 32'h10010000 with data 32'h12345678 -> dFault=1, later read returns prior word.
REQ-038 PC=32'h00400000+4*TEXT_WORDS -> instruction=0, iFault=1; next legal PC clears iFault.
REQ-039 Force wrCount to 16'hFFFE, issue 3 legal writes -> wrCount=16'hFFFF; assert rst with MemWrite=1 -> counters 0, memory unchanged.
